armleocpu_tlb_resolver: RTL and testbench
=========================================

Name: armleocpu_tlb_resolver

Overview:
- Requester-side counterpart of the page table walker: a direct-mapped translation cache that accepts VPN resolve requests from the MMU front end.
- On a miss it drives the PTW resolve interface (ptw_resolve_*) and caches successful translations.
- Returns PPN, access bits and fault flags to the requester.
- Sits between the fetch/load-store MMU logic and the PTW.

Parameters:
ENTRIES_W, 4, log2 of entry count (16 entries); index = vpn[ENTRIES_W-1:0], tag = vpn[19:ENTRIES_W]

Ports:
clk  in  1  clock, all state changes on rising edge
async_rst  in  1  asynchronous, active-high reset
resolve_request  in  1  level request; held until resolve_done is seen
resolve_virtual_address  in  20  VPN (VA[31:12]); sampled only when the request is accepted in IDLE
invalidate  in  1  flush all entries (sfence.vma)
resolve_done  out  1  one-cycle pulse: result valid
resolve_pagefault  out  1  valid with resolve_done
resolve_accessfault  out  1  valid with resolve_done
resolve_physical_address  out  22  PPN, valid with resolve_done
resolve_access_bits  out  8  {D,A,G,U,X,W,R,V}, valid with resolve_done
ptw_resolve_request  out  1  level request to the PTW, registered
ptw_resolve_virtual_address  out  20  VPN to walk, stable while ptw_resolve_request=1
ptw_resolve_done  in  1  PTW result strobe
ptw_resolve_pagefault  in  1  valid with ptw_resolve_done
ptw_resolve_accessfault  in  1  valid with ptw_resolve_done
ptw_resolve_physical_address  in  22  4K-granular PPN; the PTW has already composed megapages
ptw_resolve_access_bits  in  8  valid with ptw_resolve_done

Behaviour:
- Storage per entry: valid, tag, ppn[21:0], access[7:0]. Register arrays, combinational read.
- Reset (async, immediate):
  - state=IDLE; all valid=0; invalidate_pending=0.
  - All outputs 0, including ptw_resolve_request and ptw_resolve_virtual_address.
- FSM states: IDLE, LOOKUP, WALK, DONE.
- IDLE:
  - If invalidate=1: clear all valid bits; the request is not accepted this cycle (invalidate has priority).
  - Else if resolve_request=1: latch VPN into vpn_r; go to LOOKUP.
- LOOKUP:
  - Hit (entry[idx].valid and tag match): load the result registers from the entry, faults=0; go to DONE.
  - Miss: ptw_resolve_request<=1, ptw_resolve_virtual_address<=vpn_r; go to WALK.
- WALK:
  - Hold ptw_resolve_request and address stable until ptw_resolve_done is sampled 1.
  - On that edge:
    - Deassert ptw_resolve_request.
    - Load the result registers from the ptw_resolve_* inputs.
    - Write entry[idx] (valid=1, tag, ppn, access) only if both faults are 0 and invalidate_pending=0.
    - Go to DONE.
  - Faulting translations are never cached.
- DONE:
  - resolve_done=1 for exactly this one cycle; result outputs hold their values until the next load.
  - resolve_request is ignored in this state. Go to IDLE.
  - A requester still holding resolve_request in IDLE starts a new lookup.
- Latency:
  - Hit: accepted at edge E; resolve_done high in the cycle after E+1 (2 cycles).
  - Miss: 1 cycle to ptw_resolve_request; resolve_done asserted the cycle after ptw_resolve_done is sampled.
- Invalidate outside IDLE:
  - Sets invalidate_pending; the in-flight result is still returned to the requester but not written.
  - Pending flush executes on the first IDLE cycle (valid clear, request deferred one cycle); invalidate_pending then clears.
- Replacement: direct-mapped overwrite; no LRU.
- ptw_resolve_done outside WALK is ignored.
- Reset during WALK: ptw_resolve_request drops asynchronously; any late ptw_resolve_done is ignored.
- Fault flags are mutually exclusive from the PTW; if both are set, forward both and do not cache.

Test Plan:
1. Reset, request VPN 0x00001 -> ptw_resolve_request=1 with address 0x00001 two edges after accept. PTW returns PPN 0x000400, bits 0xCF -> resolve_done pulse, PPN 0x000400, bits 0xCF, faults 0.
2. Re-request VPN 0x00001 -> ptw_resolve_request stays 0; resolve_done 2 cycles after accept with PPN 0x000400.
3. Request VPN 0x00011 (same index, ENTRIES_W=4) -> walk, PPN 0x000123 cached. Then VPN 0x00001 -> walk again (evicted).
4. PTW returns pagefault for VPN 0x00002 -> resolve_pagefault=1 with done. Repeat -> second walk issued (not cached). Same two steps with accessfault -> same behaviour.
5. Invalidate pulse during WALK for VPN 0x00003 -> result delivered. Cached VPN 0x00001 and VPN 0x00003 both miss afterwards. invalidate=1 together with a request in IDLE -> request accepted one cycle later, and it misses.
6. Assert async_rst mid-WALK -> ptw_resolve_request=0 and resolve_done=0 immediately. After release, previously cached VPN 0x00011 misses; a stray ptw_resolve_done in IDLE produces no resolve_done.

Source files
------------

// File: rtl/armleocpu_tlb_resolver.sv
// Direct-mapped translation cache in front of the page table walker.
// Hits are answered from local entries; misses walk via ptw_resolve_* and fill on success.
//
// state  | meaning
// IDLE   | waiting for a request; executes flushes (immediate or pending)
// LOOKUP | compare entry[idx] against the latched VPN
// WALK   | PTW request held until ptw_resolve_done_i
// DONE   | resolve_done_o high for this single cycle
module armleocpu_tlb_resolver #(
  parameter int ENTRIES_W = 4
) (
  input  logic        clk_i,
  input  logic        async_rst_i,
  input  logic        resolve_request_i,
  input  logic [19:0] resolve_virtual_address_i,
  input  logic        invalidate_i,
  output logic        resolve_done_o,
  output logic        resolve_pagefault_o,
  output logic        resolve_accessfault_o,
  output logic [21:0] resolve_physical_address_o,
  output logic [7:0]  resolve_access_bits_o,
  output logic        ptw_resolve_request_o,
  output logic [19:0] ptw_resolve_virtual_address_o,
  input  logic        ptw_resolve_done_i,
  input  logic        ptw_resolve_pagefault_i,
  input  logic        ptw_resolve_accessfault_i,
  input  logic [21:0] ptw_resolve_physical_address_i,
  input  logic [7:0]  ptw_resolve_access_bits_i
);

  localparam int ENTRIES = 1 << ENTRIES_W;
  localparam int TAG_W   = 20 - ENTRIES_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, WALK, DONE} state_t;

  state_t               state_q;
  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q     [ENTRIES];
  logic [21:0]          ent_ppn_q [ENTRIES];
  logic [7:0]           ent_acc_q [ENTRIES];
  logic [19:0]          vpn_q;
  logic                 inv_pending_q;
  logic                 done_q;
  logic                 pf_q;
  logic                 af_q;
  logic [21:0]          ppn_q;
  logic [7:0]           bits_q;
  logic                 ptw_req_q;
  logic [19:0]          ptw_va_q;

  logic [ENTRIES_W-1:0] idx;
  logic [TAG_W-1:0]     vpn_tag;
  logic                 hit;

  assign idx     = vpn_q[ENTRIES_W-1:0];
  assign vpn_tag = vpn_q[19:ENTRIES_W];
  assign hit     = valid_q[idx] && (tag_q[idx] == vpn_tag);

  assign resolve_done_o                = done_q;
  assign resolve_pagefault_o           = pf_q;
  assign resolve_accessfault_o         = af_q;
  assign resolve_physical_address_o    = ppn_q;
  assign resolve_access_bits_o         = bits_q;
  assign ptw_resolve_request_o         = ptw_req_q;
  assign ptw_resolve_virtual_address_o = ptw_va_q;

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      vpn_q         <= '0;
      inv_pending_q <= 1'b0;
      done_q        <= 1'b0;
      pf_q          <= 1'b0;
      af_q          <= 1'b0;
      ppn_q         <= '0;
      bits_q        <= '0;
      ptw_req_q     <= 1'b0;
      ptw_va_q      <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]     <= '0;
        ent_ppn_q[i] <= '0;
        ent_acc_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // A flush seen mid-transaction is deferred to the next IDLE cycle
      if (invalidate_i && state_q != IDLE)
        inv_pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (invalidate_i || inv_pending_q) begin
            valid_q       <= '0;
            inv_pending_q <= 1'b0;
          end else if (resolve_request_i) begin
            vpn_q   <= resolve_virtual_address_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            pf_q    <= 1'b0;
            af_q    <= 1'b0;
            ppn_q   <= ent_ppn_q[idx];
            bits_q  <= ent_acc_q[idx];
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            ptw_req_q <= 1'b1;
            ptw_va_q  <= vpn_q;
            state_q   <= WALK;
          end
        end
        WALK: begin
          if (ptw_resolve_done_i) begin
            ptw_req_q <= 1'b0;
            pf_q      <= ptw_resolve_pagefault_i;
            af_q      <= ptw_resolve_accessfault_i;
            ppn_q     <= ptw_resolve_physical_address_i;
            bits_q    <= ptw_resolve_access_bits_i;
            done_q    <= 1'b1;
            state_q   <= DONE;
            // An invalidate arriving on this very edge also blocks the fill
            if (!ptw_resolve_pagefault_i && !ptw_resolve_accessfault_i &&
                !inv_pending_q && !invalidate_i) begin
              valid_q[idx]   <= 1'b1;
              tag_q[idx]     <= vpn_tag;
              ent_ppn_q[idx] <= ptw_resolve_physical_address_i;
              ent_acc_q[idx] <= ptw_resolve_access_bits_i;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_tlb_resolver.sv
// Directed bench for armleocpu_tlb_resolver: fill, hit, eviction, faults, flush and reset cases.
module tb_armleocpu_tlb_resolver;

  logic        clk_i = 1'b0;
  logic        async_rst_i;
  logic        resolve_request_i;
  logic [19:0] resolve_virtual_address_i;
  logic        invalidate_i;
  logic        resolve_done_o;
  logic        resolve_pagefault_o;
  logic        resolve_accessfault_o;
  logic [21:0] resolve_physical_address_o;
  logic [7:0]  resolve_access_bits_o;
  logic        ptw_resolve_request_o;
  logic [19:0] ptw_resolve_virtual_address_o;
  logic        ptw_resolve_done_i;
  logic        ptw_resolve_pagefault_i;
  logic        ptw_resolve_accessfault_i;
  logic [21:0] ptw_resolve_physical_address_i;
  logic [7:0]  ptw_resolve_access_bits_i;

  int errors = 0;
  int checks = 0;

  armleocpu_tlb_resolver #(.ENTRIES_W(4)) dut (
    .clk_i                          (clk_i),
    .async_rst_i                    (async_rst_i),
    .resolve_request_i              (resolve_request_i),
    .resolve_virtual_address_i      (resolve_virtual_address_i),
    .invalidate_i                   (invalidate_i),
    .resolve_done_o                 (resolve_done_o),
    .resolve_pagefault_o            (resolve_pagefault_o),
    .resolve_accessfault_o          (resolve_accessfault_o),
    .resolve_physical_address_o     (resolve_physical_address_o),
    .resolve_access_bits_o          (resolve_access_bits_o),
    .ptw_resolve_request_o          (ptw_resolve_request_o),
    .ptw_resolve_virtual_address_o  (ptw_resolve_virtual_address_o),
    .ptw_resolve_done_i             (ptw_resolve_done_i),
    .ptw_resolve_pagefault_i        (ptw_resolve_pagefault_i),
    .ptw_resolve_accessfault_i      (ptw_resolve_accessfault_i),
    .ptw_resolve_physical_address_i (ptw_resolve_physical_address_i),
    .ptw_resolve_access_bits_i      (ptw_resolve_access_bits_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Full request/response on a fixed schedule; the PTW answers one cycle after it is asked.
  task automatic do_access(
    input  logic [19:0] vpn,
    input  logic        t_pf, t_af,
    input  logic [21:0] t_ppn,
    input  logic [7:0]  t_bits,
    output logic        walked,
    output logic [19:0] walk_va,
    output logic        done_seen,
    output logic        o_pf, o_af,
    output logic [21:0] o_ppn,
    output logic [7:0]  o_bits,
    output logic        req_at_done,
    output logic        done_after
  );
    resolve_request_i         = 1'b1;
    resolve_virtual_address_i = vpn;
    step();
    resolve_virtual_address_i = ~vpn;
    step();
    walked  = ptw_resolve_request_o;
    walk_va = ptw_resolve_virtual_address_o;
    if (walked) begin
      ptw_resolve_done_i             = 1'b1;
      ptw_resolve_pagefault_i        = t_pf;
      ptw_resolve_accessfault_i      = t_af;
      ptw_resolve_physical_address_i = t_ppn;
      ptw_resolve_access_bits_i      = t_bits;
      step();
      ptw_resolve_done_i             = 1'b0;
      ptw_resolve_pagefault_i        = 1'b0;
      ptw_resolve_accessfault_i      = 1'b0;
    end
    done_seen   = resolve_done_o;
    o_pf        = resolve_pagefault_o;
    o_af        = resolve_accessfault_o;
    o_ppn       = resolve_physical_address_o;
    o_bits      = resolve_access_bits_o;
    req_at_done = ptw_resolve_request_o;
    resolve_request_i = 1'b0;
    step();
    done_after = resolve_done_o;
  endtask

  task automatic test_reset();
    async_rst_i = 1'b1;
    resolve_request_i = 1'b0;
    resolve_virtual_address_i = '0;
    invalidate_i = 1'b0;
    ptw_resolve_done_i = 1'b0;
    ptw_resolve_pagefault_i = 1'b0;
    ptw_resolve_accessfault_i = 1'b0;
    ptw_resolve_physical_address_i = '0;
    ptw_resolve_access_bits_i = '0;
    #1;
    checks++;
    if ({resolve_done_o, resolve_pagefault_o, resolve_accessfault_o, ptw_resolve_request_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got done/pf/af/ptwreq=%b want 0000",
               {resolve_done_o, resolve_pagefault_o, resolve_accessfault_o, ptw_resolve_request_o});
    end
    checks++;
    if ({resolve_physical_address_o, resolve_access_bits_o, ptw_resolve_virtual_address_o} !== 50'h0) begin
      errors++;
      $display("FAIL reset_data: got ppn=%h bits=%h ptwva=%h want all 0",
               resolve_physical_address_o, resolve_access_bits_o, ptw_resolve_virtual_address_o);
    end
    step();
    async_rst_i = 1'b0;
    step();
  endtask

  task automatic test_miss_fill();
    logic w, d, pf, af, rq, da; logic [19:0] va; logic [21:0] ppn; logic [7:0] bits;
    do_access(20'h00001, 1'b0, 1'b0, 22'h000400, 8'hCF, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, va} !== {1'b1, 20'h00001}) begin
      errors++; $display("FAIL miss_walk: got req=%b va=%h want req=1 va=00001", w, va);
    end
    checks++;
    if ({d, pf, af, rq} !== 4'b1000) begin
      errors++; $display("FAIL miss_done: got done/pf/af/ptwreq=%b want 1000", {d, pf, af, rq});
    end
    checks++;
    if ({ppn, bits} !== {22'h000400, 8'hCF}) begin
      errors++; $display("FAIL miss_result: got ppn=%h bits=%h want 000400 cf", ppn, bits);
    end
    checks++;
    if (da !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got done=%b after DONE want 0", da);
    end
  endtask

  task automatic test_hit();
    logic w, d, pf, af, rq, da; logic [19:0] va; logic [21:0] ppn; logic [7:0] bits;
    do_access(20'h00001, 1'b0, 1'b0, 22'h3FFFFF, 8'h00, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d} !== 2'b01) begin
      errors++; $display("FAIL hit_latency: got ptwreq=%b done=%b two cycles after accept want 0 1", w, d);
    end
    checks++;
    if ({ppn, bits, pf, af} !== {22'h000400, 8'hCF, 2'b00}) begin
      errors++; $display("FAIL hit_result: got ppn=%h bits=%h pf=%b af=%b want 000400 cf 0 0", ppn, bits, pf, af);
    end
  endtask

  task automatic test_conflict();
    logic w, d, pf, af, rq, da; logic [19:0] va; logic [21:0] ppn; logic [7:0] bits;
    do_access(20'h00011, 1'b0, 1'b0, 22'h000123, 8'h0F, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, va, ppn} !== {1'b1, 20'h00011, 22'h000123}) begin
      errors++; $display("FAIL conflict_walk: got req=%b va=%h ppn=%h want 1 00011 000123", w, va, ppn);
    end
    do_access(20'h00011, 1'b0, 1'b0, 22'h3FFFFF, 8'h00, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d, ppn, bits} !== {2'b01, 22'h000123, 8'h0F}) begin
      errors++; $display("FAIL conflict_hit: got req=%b done=%b ppn=%h bits=%h want 0 1 000123 0f", w, d, ppn, bits);
    end
    do_access(20'h00001, 1'b0, 1'b0, 22'h000400, 8'hCF, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, va} !== {1'b1, 20'h00001}) begin
      errors++; $display("FAIL evicted_rewalk: got req=%b va=%h want 1 00001", w, va);
    end
  endtask

  task automatic test_faults();
    logic w, d, pf, af, rq, da; logic [19:0] va; logic [21:0] ppn; logic [7:0] bits;
    do_access(20'h00002, 1'b1, 1'b0, 22'h0000AB, 8'h01, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d, pf, af} !== 4'b1110) begin
      errors++; $display("FAIL pagefault: got req/done/pf/af=%b want 1110", {w, d, pf, af});
    end
    do_access(20'h00002, 1'b0, 1'b1, 22'h0000AB, 8'h01, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d, pf, af} !== 4'b1101) begin
      errors++; $display("FAIL pagefault_not_cached_af: got req/done/pf/af=%b want 1101", {w, d, pf, af});
    end
    do_access(20'h00002, 1'b1, 1'b1, 22'h0000AB, 8'h01, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d, pf, af} !== 4'b1111) begin
      errors++; $display("FAIL accessfault_not_cached_both: got req/done/pf/af=%b want 1111", {w, d, pf, af});
    end
    do_access(20'h00002, 1'b0, 1'b0, 22'h0000AB, 8'h01, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d, pf, af, ppn} !== {4'b1100, 22'h0000AB}) begin
      errors++; $display("FAIL both_faults_not_cached: got req/done/pf/af=%b ppn=%h want 1100 0000ab", {w, d, pf, af}, ppn);
    end
  endtask

  task automatic test_invalidate();
    logic w, d, pf, af, rq, da; logic [19:0] va; logic [21:0] ppn; logic [7:0] bits;
    resolve_request_i = 1'b1;
    resolve_virtual_address_i = 20'h00003;
    step();
    step();
    checks++;
    if (ptw_resolve_request_o !== 1'b1) begin
      errors++; $display("FAIL inv_walk_start: got ptwreq=%b want 1", ptw_resolve_request_o);
    end
    invalidate_i = 1'b1;
    step();
    invalidate_i = 1'b0;
    ptw_resolve_done_i = 1'b1;
    ptw_resolve_physical_address_i = 22'h000333;
    ptw_resolve_access_bits_i = 8'hC7;
    step();
    ptw_resolve_done_i = 1'b0;
    checks++;
    if ({resolve_done_o, resolve_physical_address_o, resolve_access_bits_o} !== {1'b1, 22'h000333, 8'hC7}) begin
      errors++; $display("FAIL inv_walk_result: got done=%b ppn=%h bits=%h want 1 000333 c7",
                         resolve_done_o, resolve_physical_address_o, resolve_access_bits_o);
    end
    resolve_request_i = 1'b0;
    step();
    step();
    do_access(20'h00001, 1'b0, 1'b0, 22'h000400, 8'hCF, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d} !== 2'b11) begin
      errors++; $display("FAIL pending_flush: got req=%b done=%b for vpn 00001 want 1 1", w, d);
    end
    do_access(20'h00003, 1'b0, 1'b0, 22'h000333, 8'hC7, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d} !== 2'b11) begin
      errors++; $display("FAIL pending_no_fill: got req=%b done=%b for vpn 00003 want 1 1", w, d);
    end
    invalidate_i = 1'b1;
    resolve_request_i = 1'b1;
    resolve_virtual_address_i = 20'h00003;
    step();
    invalidate_i = 1'b0;
    step();
    checks++;
    if ({ptw_resolve_request_o, resolve_done_o} !== 2'b00) begin
      errors++; $display("FAIL inv_priority: got ptwreq=%b done=%b one cycle after flush want 0 0",
                         ptw_resolve_request_o, resolve_done_o);
    end
    step();
    checks++;
    if ({ptw_resolve_request_o, ptw_resolve_virtual_address_o} !== {1'b1, 20'h00003}) begin
      errors++; $display("FAIL inv_deferred_miss: got ptwreq=%b va=%h want 1 00003",
                         ptw_resolve_request_o, ptw_resolve_virtual_address_o);
    end
    ptw_resolve_done_i = 1'b1;
    step();
    ptw_resolve_done_i = 1'b0;
    resolve_request_i = 1'b0;
    step();
  endtask

  task automatic test_reset_walk();
    logic w, d, pf, af, rq, da; logic [19:0] va; logic [21:0] ppn; logic [7:0] bits;
    do_access(20'h00011, 1'b0, 1'b0, 22'h000123, 8'h0F, w, va, d, pf, af, ppn, bits, rq, da);
    resolve_request_i = 1'b1;
    resolve_virtual_address_i = 20'h00005;
    step();
    step();
    checks++;
    if (ptw_resolve_request_o !== 1'b1) begin
      errors++; $display("FAIL rst_walk_start: got ptwreq=%b want 1", ptw_resolve_request_o);
    end
    async_rst_i = 1'b1;
    #1;
    checks++;
    if ({ptw_resolve_request_o, resolve_done_o, resolve_physical_address_o} !== 24'h0) begin
      errors++; $display("FAIL async_reset: got ptwreq=%b done=%b ppn=%h want 0 0 000000",
                         ptw_resolve_request_o, resolve_done_o, resolve_physical_address_o);
    end
    resolve_request_i = 1'b0;
    ptw_resolve_done_i = 1'b1;
    ptw_resolve_physical_address_i = 22'h000555;
    step();
    async_rst_i = 1'b0;
    step();
    step();
    checks++;
    if ({resolve_done_o, ptw_resolve_request_o, resolve_physical_address_o} !== 24'h0) begin
      errors++; $display("FAIL stray_ptw_done: got done=%b ptwreq=%b ppn=%h want 0 0 000000",
                         resolve_done_o, ptw_resolve_request_o, resolve_physical_address_o);
    end
    ptw_resolve_done_i = 1'b0;
    do_access(20'h00011, 1'b0, 1'b0, 22'h000123, 8'h0F, w, va, d, pf, af, ppn, bits, rq, da);
    checks++;
    if ({w, d} !== 2'b11) begin
      errors++; $display("FAIL reset_clears_cache: got req=%b done=%b for vpn 00011 want 1 1", w, d);
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_conflict();
    test_faults();
    test_invalidate();
    test_reset_walk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
